// File: rtl/mul_sequencer_if.sv
// Execute-stage multiply handshake: start/abort and operands in, stall request
// and flagged product out.
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic             AccumulateE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] AccE;
    logic             AbortE;
    logic             BusyE;
    logic             DoneE;
    logic [WIDTH-1:0] ResultE;
    logic             ResultNE;
    logic             ResultZE;

    modport master (
        output StartE, AccumulateE, SrcAE, SrcBE, AccE, AbortE,
        input  BusyE, DoneE, ResultE, ResultNE, ResultZE
    );

    modport slave (
        input  StartE, AccumulateE, SrcAE, SrcBE, AccE, AbortE,
        output BusyE, DoneE, ResultE, ResultNE, ResultZE
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiply (with optional accumulate) that stalls Execute
// while it iterates and presents the product plus N/Z flags for one cycle.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mul_sequencer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_z_q, result_z_d;
    logic [WIDTH-1:0] add_s;
    logic [WIDTH-1:0] shifted_s;

    // Next-state and datapath for the three-state iteration controller
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        product_d  = product_q;
        count_d    = count_q;
        result_d   = result_q;
        result_z_d = result_z_q;
        add_s      = product_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
        shifted_s  = mplier_q >> 1;

        case (state_q)
            IDLE: begin
                if (bus.StartE) begin
                    mcand_d   = bus.SrcAE;
                    mplier_d  = bus.SrcBE;
                    product_d = bus.AccumulateE ? bus.AccE : {WIDTH{1'b0}};
                    count_d   = {CW{1'b0}};
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                product_d = add_s;
                mcand_d   = mcand_q << 1;
                mplier_d  = shifted_s;
                count_d   = count_q + {{(CW-1){1'b0}}, 1'b1};
                // Result is captured on entry to DONE so it is a flop output there
                if ((shifted_s == {WIDTH{1'b0}}) || (count_d == CW'(WIDTH))) begin
                    state_d    = DONE;
                    result_d   = add_s;
                    result_z_d = (add_s == {WIDTH{1'b0}});
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.AbortE) begin
            state_d    = IDLE;
            result_d   = result_q;
            result_z_d = result_z_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mcand_q    <= {WIDTH{1'b0}};
            mplier_q   <= {WIDTH{1'b0}};
            product_q  <= {WIDTH{1'b0}};
            count_q    <= {CW{1'b0}};
            result_q   <= {WIDTH{1'b0}};
            result_z_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            product_q  <= product_d;
            count_q    <= count_d;
            result_q   <= result_d;
            result_z_q <= result_z_d;
        end
    end

    // Stall must rise in the same cycle the multiply is accepted
    assign bus.BusyE    = ((state_q == IDLE) && bus.StartE) || (state_q == RUN);
    assign bus.DoneE    = (state_q == DONE);
    assign bus.ResultE  = result_q;
    assign bus.ResultNE = result_q[WIDTH-1];
    assign bus.ResultZE = result_z_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised and directed checks of mul_sequencer against an arithmetic model
// of product, accumulate and iteration latency.
module tb_mul_sequencer;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [W-1:0] last_res;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_k(input logic [W-1:0] b);
        int k;
        k = 1;
        for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [W-1:0] acc, input logic accum);
        logic [63:0] full;
        full = 64'(a) * 64'(b) + (accum ? 64'(acc) : 64'd0);
        return full[W-1:0];
    endfunction

    // Entered just after a rising edge; returns just after the edge ending DONE
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] acc, input logic accum);
        int k;
        logic [W-1:0] exp;
        k   = model_k(b);
        exp = model_res(a, b, acc, accum);
        bus.StartE = 1'b1; bus.SrcAE = a; bus.SrcBE = b; bus.AccE = acc; bus.AccumulateE = accum;
        @(negedge clk);
        check("busy_c0", 64'(bus.BusyE), 64'd1);
        check("hold_c0", 64'(bus.ResultE), 64'(last_res));
        @(posedge clk); #1;
        bus.StartE = 1'b0; bus.SrcAE = $urandom; bus.SrcBE = $urandom; bus.AccE = $urandom;
        bus.AccumulateE = ~accum;
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            check("busy_run", 64'(bus.BusyE), 64'd1);
            check("done_run", 64'(bus.DoneE), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("done", 64'(bus.DoneE), 64'd1);
        check("busy_done", 64'(bus.BusyE), 64'd0);
        check("result", 64'(bus.ResultE), 64'(exp));
        check("flag_n", 64'(bus.ResultNE), 64'(exp[W-1]));
        check("flag_z", 64'(bus.ResultZE), 64'(exp == '0));
        last_res = exp;
        @(posedge clk); #1;
    endtask

    initial begin
        int dones;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] a, b, acc;
        n_vec = 0; n_err = 0; last_res = '0;
        reset = 1'b1;
        bus.StartE = 1'b0; bus.AccumulateE = 1'b0; bus.AbortE = 1'b0;
        bus.SrcAE = '0; bus.SrcBE = '0; bus.AccE = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.BusyE), 64'd0);
        check("rst_done", 64'(bus.DoneE), 64'd0);
        check("rst_res", 64'(bus.ResultE), 64'd0);
        check("rst_n", 64'(bus.ResultNE), 64'd0);
        check("rst_z", 64'(bus.ResultZE), 64'd1);
        @(posedge clk); #1;

        run_mul(32'd7, 32'd6, 32'd0, 1'b0);
        run_mul(32'd3, 32'd5, 32'd10, 1'b1);
        run_mul(32'd3, 32'd5, 32'h0000DEAD, 1'b0);
        run_mul(32'h1234, 32'd0, 32'd0, 1'b0);
        run_mul(32'h1234, 32'd0, 32'h80000000, 1'b1);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0);

        // StartE held through DONE, then 2*2 started in the following IDLE cycle
        dones = 0;
        exp_q.push_back(32'd42);
        exp_q.push_back(32'd4);
        bus.StartE = 1'b1; bus.AccumulateE = 1'b0; bus.SrcAE = 32'd7; bus.SrcBE = 32'd6;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.DoneE) begin
                dones++;
                if (exp_q.size() > 0) check("b2b_res", 64'(bus.ResultE), 64'(exp_q.pop_front()));
                else check("b2b_extra_done", 64'd1, 64'd0);
            end
            check("b2b_done_cycle", 64'(bus.DoneE), 64'((c == 4) || (c == 8)));
            @(posedge clk); #1;
            if (c == 0) begin bus.SrcAE = 32'd2; bus.SrcBE = 32'd2; end
            if (c == 5) bus.StartE = 1'b0;
        end
        check("b2b_count", 64'(dones), 64'd2);
        last_res = 32'd4;

        // Abort at cycle 2 of a k=10 run: result must be held
        bus.StartE = 1'b1; bus.SrcAE = $urandom; bus.SrcBE = 32'h200 | ($urandom & 32'h1FF);
        @(posedge clk); #1 bus.StartE = 1'b0;
        @(posedge clk); #1 bus.AbortE = 1'b1;
        @(posedge clk); #1 bus.AbortE = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_busy", 64'(bus.BusyE), 64'd0);
            check("abort_done", 64'(bus.DoneE), 64'd0);
            check("abort_hold", 64'(bus.ResultE), 64'(last_res));
            @(posedge clk); #1;
        end

        // Abort on the final RUN cycle of a k=3 run: no DONE
        bus.StartE = 1'b1; bus.SrcAE = 32'd9; bus.SrcBE = 32'd5;
        @(posedge clk); #1 bus.StartE = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.AbortE = 1'b1;
        @(posedge clk); #1 bus.AbortE = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_last_done", 64'(bus.DoneE), 64'd0);
            check("abort_last_hold", 64'(bus.ResultE), 64'(last_res));
            @(posedge clk); #1;
        end

        // Reset at cycle 5 of a long run clears the result
        bus.StartE = 1'b1; bus.SrcAE = 32'd5; bus.SrcBE = 32'h00400001;
        @(posedge clk); #1 bus.StartE = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        last_res = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_run_busy", 64'(bus.BusyE), 64'd0);
            check("rst_run_done", 64'(bus.DoneE), 64'd0);
            check("rst_run_res", 64'(bus.ResultE), 64'd0);
            check("rst_run_z", 64'(bus.ResultZE), 64'd1);
            @(posedge clk); #1;
        end

        // Random operands, mostly back-to-back, sometimes with idle gaps
        for (int t = 0; t < 40; t++) begin
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            acc = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            run_mul(a, b, acc, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                bus.StartE = 1'b0;
                @(negedge clk);
                check("idle_busy", 64'(bus.BusyE), 64'd0);
                check("idle_done", 64'(bus.DoneE), 64'd0);
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiply controller for the pipelined core's Execute stage. When a decoded MUL/MLA reaches Execute and its condition passes, this block takes over the multiply and runs a radix-2 shift-add over several cycles. While it runs, it asks the hazard unit to stall Fetch/Decode/Execute. When it finishes, it presents the 32-bit product, with optional accumulate, plus N/Z flags for one cycle so the instruction can advance. It replaces a single-cycle combinational multiplier in the ALU path.

## Interface
Parameters:
- WIDTH, 32, operand and result width; iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, sampled on the rising edge
- StartE  input  1  MUL/MLA in Execute with condition passed (MulOpE & CondExE)
- AccumulateE  input  1  1 = MLA (add AccE), 0 = MUL
- SrcAE  input  WIDTH  multiplicand
- SrcBE  input  WIDTH  multiplier
- AccE  input  WIDTH  accumulate operand; ignored when AccumulateE=0
- AbortE  input  1  cancel the in-flight multiply (pipeline flush due to exception or redirect)
- BusyE  output  1  stall request to the hazard unit
- DoneE  output  1  one-cycle pulse; ResultE, ResultNE and ResultZE are valid
- ResultE  output  WIDTH  low WIDTH bits of SrcA*SrcB (+Acc)
- ResultNE  output  1  ResultE[WIDTH-1]
- ResultZE  output  1  ResultE == 0

## Operation
- Registered state: multiplicand (WIDTH), multiplier (WIDTH), product (WIDTH), count, FSM state.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - If StartE=1: load multiplicand=SrcAE, multiplier=SrcBE, product = AccumulateE ? AccE : 0, count=0. Go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If multiplier[0]=1: product += multiplicand, mod 2^WIDTH.
  - Shift multiplicand left by 1. Shift multiplier right by 1 (logical). count++.
  - Go to DONE when the shifted multiplier == 0 or count reaches WIDTH. Otherwise stay in RUN.
- DONE:
  - DoneE=1. ResultE = product.
  - StartE is ignored in this state. The instruction is still in Execute this cycle and must not retrigger.
  - Always go to IDLE.
- BusyE = (state==IDLE & StartE) | (state==RUN). This is combinational so the pipeline stalls in the same cycle the multiply starts. BusyE=0 in DONE, so the instruction leaves Execute at the end of the DONE cycle.
- AbortE=1 in any state returns the FSM to IDLE on the next edge:
  - DoneE is not asserted and ResultE is not updated.
  - AbortE takes priority over StartE.
- ResultE, ResultNE and ResultZE are held from the last DONE until the next DONE.
- Overflow above WIDTH bits is discarded. No carry or overflow flag is produced; the controller leaves C and V unchanged for MUL/MLA.
- Reset values: state=IDLE, BusyE=0, DoneE=0, ResultE=0, ResultNE=0, ResultZE=1, and all internal registers 0.

## Timing
- Let k = index of the highest set bit of SrcBE, plus 1. k=1 when SrcBE=0. k=WIDTH when bit WIDTH-1 is set.
- Cycle 0: IDLE with StartE=1. BusyE=1. Operands captured.
- Cycles 1..k: RUN, BusyE=1.
- Cycle k+1: DONE, DoneE=1, BusyE=0.
- The Execute stage holds for k+1 extra cycles. Latency from start to result ranges from 2 to WIDTH+1 cycles.
- Back-to-back multiplies: the earliest next start is the cycle after DONE (IDLE with StartE=1). There is no dead cycle beyond DONE.
- Reset asserted mid-RUN: IDLE after the edge, no DoneE, ResultE=0.
- AbortE and the final RUN cycle together: abort wins, and there is no DONE.

## Test plan
- MUL 7*6, StartE for one cycle → BusyE high for cycles 0-3, DoneE at cycle 4, ResultE=42, N=0, Z=0.
- MLA 3*5 + 10 → k=3, DoneE at cycle 4, ResultE=25. Repeat with AccumulateE=0 and AccE=0xDEAD → ResultE=15.
- SrcBE=0, SrcAE=0x1234, MUL → DoneE at cycle 2, ResultE=0, ResultZE=1. Same operands with MLA and AccE=0x80000000 → ResultE=0x80000000, ResultNE=1.
- 0xFFFFFFFF * 0xFFFFFFFF → BusyE for 33 cycles, DoneE at cycle 33, ResultE=0x00000001 (wrap-around).
- StartE held high through DONE, then a second multiply 2*2 started immediately after → exactly two DoneE pulses, with results 42 then 4 and no retrigger.
- AbortE at cycle 2 of a k=10 run, and separately reset at cycle 5 → next cycle IDLE with BusyE=0, no DoneE. ResultE keeps its previous value after abort and is 0 after reset.
